// File: rtl/csi2_pkg.sv
// Shared CSI-2 constants, state encodings and payload types.
package csi2_pkg;

    localparam logic [5:0]  RAW10_DT        = 6'h2B;
    localparam int unsigned PIX_W           = 10;
    localparam int unsigned BYTES_PER_GROUP = 5;
    localparam int unsigned WORD_BYTES      = 8;
    localparam int unsigned RESIDUE_BYTES   = 12;
    localparam int unsigned GROUP_W         = BYTES_PER_GROUP * 8;
    localparam int unsigned WORD_W          = WORD_BYTES * 8;
    localparam int unsigned RESIDUE_W       = RESIDUE_BYTES * 8;
    localparam int unsigned FILL_W          = 4;
    localparam int unsigned COUNT_W         = 16;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } pack_state_e;

    typedef struct packed {
        logic [PIX_W-1:0] p3;
        logic [PIX_W-1:0] p2;
        logic [PIX_W-1:0] p1;
        logic [PIX_W-1:0] p0;
    } raw10_group_t;

endpackage

// File: rtl/raw10_group_format.sv
// Formats one 4-pixel RAW10 group into its 5-byte wire order (byte 0 in [7:0]).
module raw10_group_format
    import csi2_pkg::*;
(
    input  raw10_group_t         grp_i,
    output logic [GROUP_W-1:0]   bytes_o
);

    // MSB bytes of each pixel, then one byte collecting the four LSB pairs
    always_comb begin
        bytes_o        = '0;
        bytes_o[7:0]   = grp_i.p0[9:2];
        bytes_o[15:8]  = grp_i.p1[9:2];
        bytes_o[23:16] = grp_i.p2[9:2];
        bytes_o[31:24] = grp_i.p3[9:2];
        bytes_o[39:32] = {grp_i.p3[1:0], grp_i.p2[1:0], grp_i.p1[1:0], grp_i.p0[1:0]};
    end

endmodule

// File: rtl/raw10_byte_packer.sv
// RAW10 pixel-group to 64-bit CSI-2 payload word gearbox with line flush.
module raw10_byte_packer
    import csi2_pkg::*;
(
    input  logic                 byte_clk_i,
    input  logic                 reset_i,
    input  logic                 line_start_i,
    input  logic                 flush_i,
    input  logic                 pix_valid_i,
    output logic                 pix_ready_o,
    input  logic [PIX_W-1:0]     pixel_0_i,
    input  logic [PIX_W-1:0]     pixel_1_i,
    input  logic [PIX_W-1:0]     pixel_2_i,
    input  logic [PIX_W-1:0]     pixel_3_i,
    output logic [WORD_W-1:0]    byte_data_o,
    output logic                 byte_data_en_o,
    input  logic                 byte_ready_i,
    output logic [COUNT_W-1:0]   word_count_o
);

    pack_state_e             state_q, state_d;
    logic [RESIDUE_W-1:0]    res_q, res_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic                    en_q, en_d;
    logic [COUNT_W-1:0]      wc_q, wc_d;
    logic                    run_q;

    raw10_group_t            grp;
    logic [GROUP_W-1:0]      grp_bytes;
    logic                    slot_free;
    logic                    accept;
    logic                    ls_eff;
    logic                    handshake;
    logic [RESIDUE_W-1:0]    base_res, app_res;
    logic [FILL_W-1:0]       base_fill, app_fill, rem_fill;

    assign grp = '{p3: pixel_3_i, p2: pixel_2_i, p1: pixel_1_i, p0: pixel_0_i};

    raw10_group_format u_fmt (
        .grp_i   (grp),
        .bytes_o (grp_bytes)
    );

    // Output slot is free when empty or being taken this cycle
    assign slot_free   = !en_q | byte_ready_i;
    assign pix_ready_o = run_q & slot_free & (state_q != ST_FLUSH);
    assign accept      = pix_valid_i & pix_ready_o;
    assign ls_eff      = line_start_i & !en_q;
    assign handshake   = en_q & byte_ready_i;

    // Append the accepted group above the current residue (new line starts empty)
    always_comb begin
        base_res  = ls_eff ? '0 : res_q;
        base_fill = ls_eff ? '0 : fill_q;
        app_res   = base_res;
        app_fill  = base_fill;
        if (accept) begin
            app_res  = base_res | (RESIDUE_W'(grp_bytes) << {base_fill, 3'b000});
            app_fill = base_fill + FILL_W'(BYTES_PER_GROUP);
        end
        rem_fill = app_fill - FILL_W'(WORD_BYTES);
    end

    // Next-state, word load and line counter
    always_comb begin
        state_d = state_q;
        res_d   = app_res;
        fill_d  = app_fill;
        data_d  = data_q;
        en_d    = en_q & !byte_ready_i;
        wc_d    = wc_q;

        if (ls_eff) begin
            wc_d = '0;
        end else if (handshake && (wc_q != {COUNT_W{1'b1}})) begin
            wc_d = wc_q + COUNT_W'(1);
        end

        case (state_q)
            ST_FLUSH: begin
                // Residue was already zero-padded by invariant; ship it once the slot frees
                if (slot_free) begin
                    data_d  = res_q[WORD_W-1:0];
                    en_d    = 1'b1;
                    res_d   = '0;
                    fill_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                if (ls_eff) begin
                    state_d = ST_FILL;
                end
                if (app_fill >= FILL_W'(WORD_BYTES)) begin
                    data_d  = app_res[WORD_W-1:0];
                    en_d    = 1'b1;
                    res_d   = app_res >> WORD_W;
                    fill_d  = rem_fill;
                    if (flush_i) begin
                        state_d = (rem_fill != '0) ? ST_FLUSH : ST_DRAIN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (flush_i && (app_fill != '0)) begin
                    if (slot_free) begin
                        data_d  = app_res[WORD_W-1:0];
                        en_d    = 1'b1;
                        res_d   = '0;
                        fill_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else if ((state_q == ST_DRAIN) && slot_free) begin
                    state_d = ST_FILL;
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge byte_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_FILL;
            res_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            wc_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            en_q    <= en_d;
            wc_q    <= wc_d;
            run_q   <= 1'b1;
        end
    end

    assign byte_data_o    = data_q;
    assign byte_data_en_o = en_q;
    assign word_count_o   = wc_q;

endmodule

// File: tb/tb_raw10_byte_packer.sv
// Randomized and directed checks of raw10_byte_packer against a byte-queue model.
module tb_raw10_byte_packer;

    logic        byte_clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        line_start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic        pix_ready_o;
    logic [9:0]  pixel_0_i = '0;
    logic [9:0]  pixel_1_i = '0;
    logic [9:0]  pixel_2_i = '0;
    logic [9:0]  pixel_3_i = '0;
    logic [63:0] byte_data_o;
    logic        byte_data_en_o;
    logic        byte_ready_i = 1'b0;
    logic [15:0] word_count_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: line byte stream, words owed to the consumer, word counter
    logic [7:0]  lb[$];
    logic [63:0] wq[$];
    int          wc = 0;
    bit          run = 1'b0;

    raw10_byte_packer dut (
        .byte_clk_i     (byte_clk_i),
        .reset_i        (reset_i),
        .line_start_i   (line_start_i),
        .flush_i        (flush_i),
        .pix_valid_i    (pix_valid_i),
        .pix_ready_o    (pix_ready_o),
        .pixel_0_i      (pixel_0_i),
        .pixel_1_i      (pixel_1_i),
        .pixel_2_i      (pixel_2_i),
        .pixel_3_i      (pixel_3_i),
        .byte_data_o    (byte_data_o),
        .byte_data_en_o (byte_data_en_o),
        .byte_ready_i   (byte_ready_i),
        .word_count_o   (word_count_o)
    );

    always #5 byte_clk_i = ~byte_clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_group(input logic [9:0] a, input logic [9:0] b,
                               input logic [9:0] c, input logic [9:0] d);
        logic [63:0] w;
        lb.push_back(a[9:2]);
        lb.push_back(b[9:2]);
        lb.push_back(c[9:2]);
        lb.push_back(d[9:2]);
        lb.push_back({d[1:0], c[1:0], b[1:0], a[1:0]});
        while (lb.size() >= 8) begin
            w = '0;
            for (int i = 0; i < 8; i++) w[i*8 +: 8] = lb.pop_front();
            wq.push_back(w);
        end
    endtask

    task automatic model_flush();
        logic [63:0] w;
        int n;
        if (lb.size() > 0) begin
            w = '0;
            n = lb.size();
            for (int i = 0; i < n; i++) w[i*8 +: 8] = lb.pop_front();
            wq.push_back(w);
        end
    endtask

    // One clock: drive at negedge, compare, then advance the model past the next posedge
    task automatic step(input bit v, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] c, input logic [9:0] d,
                        input bit fl, input bit ls, input bit br);
        bit m_en, m_rdy;
        @(negedge byte_clk_i);
        pix_valid_i  = v;
        pixel_0_i    = a;
        pixel_1_i    = b;
        pixel_2_i    = c;
        pixel_3_i    = d;
        flush_i      = fl;
        line_start_i = ls;
        byte_ready_i = br;
        #1;
        m_en  = (wq.size() > 0);
        m_rdy = run && (wq.size() < 2) && (!m_en || br);
        check_eq("pix_ready", 64'(pix_ready_o), 64'(m_rdy));
        check_eq("data_en", 64'(byte_data_en_o), 64'(m_en));
        if (m_en) check_eq("data", byte_data_o, wq[0]);
        check_eq("word_count", 64'(word_count_o), 64'(wc));
        if (m_en && br) begin
            void'(wq.pop_front());
            if (wc != 65535) wc++;
        end
        if (ls && !m_en) begin
            lb.delete();
            wc = 0;
        end
        if (v && m_rdy) model_group(a, b, c, d);
        if (fl) model_flush();
        run = 1'b1;
    endtask

    task automatic idle(input int n, input bit br);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, br);
    endtask

    task automatic grp(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                       input logic [9:0] d, input bit fl, input bit br);
        step(1'b1, a, b, c, d, fl, 1'b0, br);
    endtask

    task automatic new_line();
        idle(3, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic after_edge();
        @(posedge byte_clk_i);
        #1;
    endtask

    // Reset pulse of one cycle; outputs must clear asynchronously and ready stays low until an edge
    task automatic reset_pulse();
        @(negedge byte_clk_i);
        pix_valid_i  = 1'b0;
        flush_i      = 1'b0;
        line_start_i = 1'b0;
        byte_ready_i = 1'b1;
        reset_i      = 1'b0;
        #1;
        check_eq("rst_data", byte_data_o, 64'h0);
        check_eq("rst_en", 64'(byte_data_en_o), 64'h0);
        check_eq("rst_ready", 64'(pix_ready_o), 64'h0);
        check_eq("rst_wcnt", 64'(word_count_o), 64'h0);
        @(negedge byte_clk_i);
        reset_i = 1'b1;
        #1;
        check_eq("rel_ready", 64'(pix_ready_o), 64'h0);
        wq.delete();
        lb.delete();
        wc  = 0;
        run = 1'b1;
    endtask

    initial begin
        logic [9:0] r0, r1, r2, r3;
        bit v, fl, ls, br;
        reset_pulse();

        // Single mixed group then flush
        grp(10'h155, 10'h2AA, 10'h3FF, 10'h000, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        after_edge();
        check_eq("one_group_word", byte_data_o, 64'h00000039_00FFAA55);
        idle(1, 1'b1);
        after_edge();
        check_eq("one_group_wcnt", 64'(word_count_o), 64'd1);

        // Eight back-to-back groups give five words and no residue
        new_line();
        for (int i = 0; i < 8; i++)
            grp(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom), 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        after_edge();
        check_eq("eight_no_word", 64'(byte_data_en_o), 64'h0);
        check_eq("eight_wcnt", 64'(word_count_o), 64'd5);

        // Three all-ones groups then flush
        new_line();
        for (int i = 0; i < 3; i++) grp(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        after_edge();
        check_eq("pad_word", byte_data_o, 64'h00FFFFFF_FFFFFFFF);
        idle(2, 1'b0);
        idle(1, 1'b1);
        after_edge();
        check_eq("pad_wcnt", 64'(word_count_o), 64'd2);

        // Line start discards four residue bytes
        new_line();
        for (int i = 0; i < 4; i++) grp(10'h111, 10'h222, 10'h333, 10'h044, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        grp(10'h2C8, 10'h001, 10'h002, 10'h003, 1'b0, 1'b0);
        grp(10'h004, 10'h005, 10'h006, 10'h007, 1'b0, 1'b0);
        after_edge();
        check_eq("ls_byte0", 64'(byte_data_o[7:0]), 64'hB2);
        check_eq("ls_wcnt", 64'(word_count_o), 64'd0);

        // Reset while a word is pending
        reset_pulse();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r0 = 10'($urandom);
            r1 = 10'($urandom);
            r2 = 10'($urandom);
            r3 = 10'($urandom);
            v  = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 19) == 0);
            ls = ($urandom_range(0, 39) == 0);
            br = ($urandom_range(0, 9) < 6);
            step(v, r0, r1, r2, r3, fl, ls, br);
            if (n == 1500) reset_pulse();
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/raw10_byte_packer.md
RAW10_BYTE_PACKER -- requirements
Module: raw10_byte_packer

Interface
REQ-001 SHALL provide port byte_clk_i, input, 1, sole clock; same byte clock that drives the CSI-2 TX payload path.
REQ-002 SHALL provide port reset_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port line_start_i, input, 1, single-cycle pulse that starts a new line.
REQ-004 SHALL provide port flush_i, input, 1, single-cycle pulse that closes the current line.
REQ-005 SHALL provide port pix_valid_i, input, 1, a 4-pixel group is present.
REQ-006 SHALL provide port pix_ready_o, output, 1, group is accepted this cycle.
REQ-007 SHALL provide ports pixel_0_i .. pixel_3_i, input, 10 each, group pixels in line order (P0 first).
REQ-008 SHALL provide port byte_data_o, output, 64, packed payload word; byte 0 in [7:0].
REQ-009 SHALL provide port byte_data_en_o, output, 1, byte_data_o valid.
REQ-010 SHALL provide port byte_ready_i, input, 1, consumer takes the word (tie to the TX ld_pyld).
REQ-011 SHALL provide port word_count_o, output, 16, number of words emitted since line_start_i.

Function
REQ-012 SHALL pack each accepted group into 5 bytes: P0[9:2], P1[9:2], P2[9:2], P3[9:2], then {P3[1:0],P2[1:0],P1[1:0],P0[1:0]}.
REQ-013 SHALL append those bytes to a 96-bit residue buffer with a fill count of 0..12 bytes.
REQ-014 SHALL treat a group as accepted when pix_valid_i and pix_ready_o are both high.
REQ-015 SHALL set pix_ready_o = !byte_data_en_o | byte_ready_i, and force it low while the FLUSH state is active.
REQ-016 SHALL, when the fill count reaches 8 or more after an accept, register the lowest 8 bytes to byte_data_o.
- byte_data_en_o rises on the next clock edge (latency 1 cycle).
- The fill count drops by 8 and the remaining bytes shift down.
REQ-017 SHALL hold byte_data_o and byte_data_en_o stable until byte_ready_i is sampled high; byte_data_en_o then falls unless a new word loads in the same cycle.
REQ-018 SHALL use states FILL (normal), FLUSH (pad pending) and DRAIN (waiting for the last word to be taken); the machine returns to FILL afterward.
REQ-019 SHALL respond to flush_i as follows:
- Fill count > 0: go to FLUSH, zero-pad the residue to 8 bytes, emit it as a word, set fill count to 0.
- Fill count = 0: no word is emitted.
REQ-020 SHALL, when flush_i coincides with an accept, include that group before padding.
REQ-021 SHALL, when flush_i makes 2 words pending, emit them in consecutive handshakes.
REQ-022 SHALL, on line_start_i, discard the residue and zero word_count_o and the fill count; a group accepted in the same cycle becomes the first group of the new line.
REQ-023 SHALL increment word_count_o on every completed output handshake; it saturates at 0xFFFF.
REQ-024 SHALL ignore line_start_i while byte_data_en_o is high; the handshake must complete first.

Reset
REQ-025 SHALL, while reset_i is low, force the following values:
- byte_data_o = 0, byte_data_en_o = 0.
- pix_ready_o = 0, word_count_o = 0.
- fill count = 0, state = FILL.
REQ-026 SHALL drop any in-flight word when reset is asserted mid-operation, and raise pix_ready_o on the first edge after reset_i rises.

Structure
REQ-027 SHALL place RAW10 data type 0x2B, the bytes-per-group constant 5, the word-bytes constant 8 and the state encodings in the shared csi2 package.
REQ-028 SHALL keep the per-group byte formatting in one combinational sub-module, raw10_group_format; gearbox, FSM and counter stay in the top module.

Verification
REQ-029 SHALL cover this scenario: one group P0=0x155, P1=0x2AA, P2=0x3FF, P3=0x000, then flush_i.
- Expected: one word with bytes 55 AA FF 00 39 00 00 00, and word_count_o=1.
REQ-030 SHALL cover this scenario: 8 back-to-back groups, byte_ready_i held high.
- Expected: exactly 5 words, fill count 0.
- A flush_i afterwards emits nothing.
REQ-031 SHALL cover this scenario: 3 groups of all 0x3FF, then flush_i.
- Expected: word 1 = all 0xFF.
- Word 2 = 7 bytes of 0xFF plus one 0x00 pad byte.
- word_count_o=2.
REQ-032 SHALL cover this scenario: byte_ready_i held low for 3 cycles while a word is pending.
- Expected: byte_data_o unchanged and pix_ready_o low for 3 cycles.
- One increment when byte_ready_i rises.
REQ-033 SHALL cover this scenario: line_start_i with 4 residue bytes present.
- Expected: residue discarded, word_count_o=0.
- The next 2 groups produce a word starting with byte P0[9:2] of the new line.
REQ-034 SHALL cover this scenario: reset_i low for 1 cycle mid-line, with byte_data_en_o high.
- Expected: all outputs at reset values on the following edge.
